// File: rtl/riscv_pkg.sv
// Shared RV32I core constants: datapath width, writeback source select and load funct3 codes.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_PC4  = 2'd2,
        WB_RSVD = 2'd3
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Load data alignment: picks the byte/halfword addressed by the low address bits and extends it.
module load_align #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] i_raw,
    input  logic [1:0]      i_offset,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_aligned
);
    import riscv_pkg::*;

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_offset)
            2'd0:    w_byte = i_raw[7:0];
            2'd1:    w_byte = i_raw[15:8];
            2'd2:    w_byte = i_raw[23:16];
            default: w_byte = i_raw[31:24];
        endcase
        // Halfword selection ignores offset bit 0.
        w_half = i_offset[1] ? i_raw[31:16] : i_raw[15:0];
    end

    always_comb begin
        case (i_funct3)
            F3_LB:   o_aligned = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_LBU:  o_aligned = {{(XLEN-8){1'b0}}, w_byte};
            F3_LH:   o_aligned = {{(XLEN-16){w_half[15]}}, w_half};
            F3_LHU:  o_aligned = {{(XLEN-16){1'b0}}, w_half};
            default: o_aligned = i_raw;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register and writeback mux; holds load data across stalls and exports forwarding.
// Optional WB_INSTRET_EN adds a 64-bit retired-instruction counter output.
module mem_wb_stage #(
    parameter int unsigned XLEN      = riscv_pkg::XLEN,
    parameter int unsigned RF_ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [RF_ADDR_W-1:0] in_rd,
    input  logic                 in_we,
    input  logic [1:0]           in_wb_sel,
    input  logic [2:0]           in_funct3,
    input  logic [XLEN-1:0]      in_alu,
    input  logic [XLEN-1:0]      in_pc4,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [XLEN-1:0]      dmem_rdata,
    output logic                 rf_w_en,
    output logic [RF_ADDR_W-1:0] rf_w_indx,
    output logic [XLEN-1:0]      rf_w_data,
    output logic                 fwd_valid,
    output logic [RF_ADDR_W-1:0] fwd_rd,
    output logic [XLEN-1:0]      fwd_data,
    output logic                 load_in_wb
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]          instret
`endif
);
    import riscv_pkg::*;

    logic                 r_valid;
    logic [RF_ADDR_W-1:0] r_rd;
    logic                 r_we;
    logic [1:0]           r_wb_sel;
    logic [2:0]           r_funct3;
    logic [XLEN-1:0]      r_alu;
    logic [XLEN-1:0]      r_pc4;
    logic                 r_hold_valid;
    logic [XLEN-1:0]      r_hold_word;

    logic [XLEN-1:0]      w_raw;
    logic [XLEN-1:0]      w_aligned;
    logic [XLEN-1:0]      w_wdata;
    logic                 w_wr_cand;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_rd     <= '0;
            r_we     <= 1'b0;
            r_wb_sel <= '0;
            r_funct3 <= '0;
            r_alu    <= '0;
            r_pc4    <= '0;
        end else if (!stall) begin
            if (flush) begin
                r_valid <= 1'b0;
            end else begin
                r_valid  <= in_valid;
                r_rd     <= in_rd;
                r_we     <= in_we;
                r_wb_sel <= in_wb_sel;
                r_funct3 <= in_funct3;
                r_alu    <= in_alu;
                r_pc4    <= in_pc4;
            end
        end
    end

    // DMEM data is only valid for one cycle; keep the first-stall-cycle word until the stall ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_valid <= 1'b0;
            r_hold_word  <= '0;
        end else if (!stall) begin
            r_hold_valid <= 1'b0;
        end else if (!r_hold_valid) begin
            r_hold_valid <= 1'b1;
            r_hold_word  <= dmem_rdata;
        end
    end

    assign w_raw = r_hold_valid ? r_hold_word : dmem_rdata;

    load_align #(.XLEN(XLEN)) u_load_align (
        .i_raw     (w_raw),
        .i_offset  (r_alu[1:0]),
        .i_funct3  (r_funct3),
        .o_aligned (w_aligned)
    );

    always_comb begin
        case (r_wb_sel)
            WB_MEM:  w_wdata = w_aligned;
            WB_PC4:  w_wdata = r_pc4;
            default: w_wdata = r_alu;
        endcase
    end

    assign w_wr_cand  = r_valid & r_we & (r_rd != '0);

    assign rf_w_en    = w_wr_cand & ~stall;
    assign rf_w_indx  = r_rd;
    assign rf_w_data  = w_wdata;
    assign fwd_valid  = w_wr_cand;
    assign fwd_rd     = r_rd;
    assign fwd_data   = w_wdata;
    assign load_in_wb = r_valid & (r_wb_sel == WB_MEM);

`ifdef WB_INSTRET_EN
    logic [63:0] r_instret;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instret <= '0;
        end else if (r_valid && !stall) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    assign instret = r_instret;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: scoreboard of expected register-file writes.
module tb_mem_wb_stage;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned RF_ADDR_W = 5;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic [RF_ADDR_W-1:0] in_rd;
    logic                 in_we;
    logic [1:0]           in_wb_sel;
    logic [2:0]           in_funct3;
    logic [XLEN-1:0]      in_alu;
    logic [XLEN-1:0]      in_pc4;
    logic                 stall;
    logic                 flush;
    logic [XLEN-1:0]      dmem_rdata;
    logic                 rf_w_en;
    logic [RF_ADDR_W-1:0] rf_w_indx;
    logic [XLEN-1:0]      rf_w_data;
    logic                 fwd_valid;
    logic [RF_ADDR_W-1:0] fwd_rd;
    logic [XLEN-1:0]      fwd_data;
    logic                 load_in_wb;
`ifdef WB_INSTRET_EN
    logic [63:0]          instret;
`endif

    typedef struct {
        logic [RF_ADDR_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    mem_wb_stage #(.XLEN(XLEN), .RF_ADDR_W(RF_ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_rd      (in_rd),
        .in_we      (in_we),
        .in_wb_sel  (in_wb_sel),
        .in_funct3  (in_funct3),
        .in_alu     (in_alu),
        .in_pc4     (in_pc4),
        .stall      (stall),
        .flush      (flush),
        .dmem_rdata (dmem_rdata),
        .rf_w_en    (rf_w_en),
        .rf_w_indx  (rf_w_indx),
        .rf_w_data  (rf_w_data),
        .fwd_valid  (fwd_valid),
        .fwd_rd     (fwd_rd),
        .fwd_data   (fwd_data),
        .load_in_wb (load_in_wb)
`ifdef WB_INSTRET_EN
        ,
        .instret    (instret)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_in(input logic v, input logic [4:0] rd, input logic we,
                          input logic [1:0] sel, input logic [2:0] f3,
                          input logic [31:0] alu, input logic [31:0] pc4);
        in_valid  = v;
        in_rd     = rd;
        in_we     = we;
        in_wb_sel = sel;
        in_funct3 = f3;
        in_alu    = alu;
        in_pc4    = pc4;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        dmem_rdata = 32'hA5A5_A5A5;
        set_in(1'b1, 5'd3, 1'b1, 2'd0, 3'd0, 32'h1111, 32'h2222);
        #3;
        n_cmp++;
        if ({rf_w_en, rf_w_indx, rf_w_data, fwd_valid, fwd_rd, fwd_data, load_in_wb} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got en=%b idx=%0d data=%h fv=%b frd=%0d fdata=%h ld=%b required all 0",
                     rf_w_en, rf_w_indx, rf_w_data, fwd_valid, fwd_rd, fwd_data, load_in_wb);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (rf_w_en !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hold_en: got %b required 0", rf_w_en);
        end
        set_in(1'b0, 5'd0, 1'b0, 2'd0, 3'd0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        exp_t e;
        set_in(1'b1, 5'd5, 1'b1, 2'd0, 3'd0, 32'h0000_1234, 32'h0000_0040);
        sb.push_back('{5'd5, 32'h0000_1234});
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (rf_w_en !== 1'b1) begin
            n_bad++;
            $display("FAIL alu_wen: got %b required 1", rf_w_en);
        end
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL alu_sb: scoreboard empty, got idx=%0d data=%h", rf_w_indx, rf_w_data);
        end else begin
            e = sb.pop_front();
            if ({rf_w_indx, rf_w_data} !== {e.rd, e.data}) begin
                n_bad++;
                $display("FAIL alu_write: got idx=%0d data=%h required idx=%0d data=%h",
                         rf_w_indx, rf_w_data, e.rd, e.data);
            end
        end
        n_cmp++;
        if ({fwd_valid, fwd_rd, fwd_data} !== {1'b1, 5'd5, 32'h0000_1234}) begin
            n_bad++;
            $display("FAIL alu_fwd: got v=%b rd=%0d data=%h required v=1 rd=5 data=00001234",
                     fwd_valid, fwd_rd, fwd_data);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (rf_w_en !== 1'b0) begin
            n_bad++;
            $display("FAIL alu_single_write: got %b required 0", rf_w_en);
        end
    endtask

    task automatic test_load(input string name, input logic [2:0] f3,
                             input logic [31:0] alu, input logic [31:0] rdata,
                             input logic [31:0] expv);
        exp_t e;
        set_in(1'b1, 5'd7, 1'b1, 2'd1, f3, alu, 32'h0000_0000);
        sb.push_back('{5'd7, expv});
        @(posedge clk); #1;
        in_valid   = 1'b0;
        dmem_rdata = rdata;
        #1;
        n_cmp++;
        if ({rf_w_en, load_in_wb} !== 2'b11) begin
            n_bad++;
            $display("FAIL %s_en: got wen=%b load_in_wb=%b required 1 1", name, rf_w_en, load_in_wb);
        end
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL %s_sb: scoreboard empty, got data=%h", name, rf_w_data);
        end else begin
            e = sb.pop_front();
            if ({rf_w_indx, rf_w_data} !== {e.rd, e.data}) begin
                n_bad++;
                $display("FAIL %s_data: got idx=%0d data=%h required idx=%0d data=%h",
                         name, rf_w_indx, rf_w_data, e.rd, e.data);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall_hold();
        exp_t e;
        set_in(1'b1, 5'd9, 1'b1, 2'd1, 3'b010, 32'h0000_2000, 32'h0);
        sb.push_back('{5'd9, 32'h1122_3344});
        @(posedge clk); #1;
        // Next instruction waits upstream while the load is stalled.
        set_in(1'b1, 5'd3, 1'b1, 2'd0, 3'd0, 32'h0000_0055, 32'h0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dmem_rdata = (i == 0) ? 32'h1122_3344 : 32'hDEAD_BEEF;
            #1;
            n_cmp++;
            if ({rf_w_en, fwd_valid, rf_w_indx, rf_w_data} !== {1'b0, 1'b1, 5'd9, 32'h1122_3344}) begin
                n_bad++;
                $display("FAIL stall_cycle%0d: got wen=%b fv=%b idx=%0d data=%h required 0 1 9 11223344",
                         i, rf_w_en, fwd_valid, rf_w_indx, rf_w_data);
            end
            @(posedge clk); #1;
        end
        stall = 1'b0;
        #1;
        n_cmp++;
        if (rf_w_en !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_release_en: got %b required 1", rf_w_en);
        end
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL stall_sb: scoreboard empty");
        end else begin
            e = sb.pop_front();
            if ({rf_w_indx, rf_w_data} !== {e.rd, e.data}) begin
                n_bad++;
                $display("FAIL stall_write: got idx=%0d data=%h required idx=%0d data=%h",
                         rf_w_indx, rf_w_data, e.rd, e.data);
            end
        end
        sb.push_back('{5'd3, 32'h0000_0055});
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL stall_next_sb: scoreboard empty");
        end else begin
            e = sb.pop_front();
            if ({rf_w_en, rf_w_indx, rf_w_data} !== {1'b1, e.rd, e.data}) begin
                n_bad++;
                $display("FAIL stall_next_write: got en=%b idx=%0d data=%h required en=1 idx=%0d data=%h",
                         rf_w_en, rf_w_indx, rf_w_data, e.rd, e.data);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rd0_jal();
        exp_t e;
        set_in(1'b1, 5'd0, 1'b1, 2'd0, 3'd0, 32'h0000_0077, 32'h0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if ({rf_w_en, fwd_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL rd0: got wen=%b fv=%b required 0 0", rf_w_en, fwd_valid);
        end
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                set_in(1'b1, 5'd1, 1'b1, 2'd2, 3'd0, 32'h0000_0999, 32'h0000_0104);
                sb.push_back('{5'd1, 32'h0000_0104});
            end else begin
                set_in(1'b1, 5'd2, 1'b1, 2'd3, 3'd0, 32'h0000_CAFE, 32'h0000_0500);
                sb.push_back('{5'd2, 32'h0000_CAFE});
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            #1;
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL wbsel%0d_sb: scoreboard empty", k);
            end else begin
                e = sb.pop_front();
                if ({rf_w_en, rf_w_indx, rf_w_data} !== {1'b1, e.rd, e.data}) begin
                    n_bad++;
                    $display("FAIL wbsel%0d_write: got en=%b idx=%0d data=%h required en=1 idx=%0d data=%h",
                             k, rf_w_en, rf_w_indx, rf_w_data, e.rd, e.data);
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        set_in(1'b1, 5'd4, 1'b1, 2'd0, 3'd0, 32'h0000_00AA, 32'h0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if ({rf_w_en, fwd_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL flush: got wen=%b fv=%b required 0 0", rf_w_en, fwd_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall_flush();
        exp_t e;
        set_in(1'b1, 5'd6, 1'b1, 2'd0, 3'd0, 32'h0000_0033, 32'h0);
        sb.push_back('{5'd6, 32'h0000_0033});
        @(posedge clk); #1;
        set_in(1'b1, 5'd10, 1'b1, 2'd0, 3'd0, 32'h0000_0044, 32'h0);
        stall = 1'b1;
        flush = 1'b1;
        #1;
        n_cmp++;
        if (rf_w_en !== 1'b0) begin
            n_bad++;
            $display("FAIL stallflush_en: got %b required 0", rf_w_en);
        end
        @(posedge clk); #1;
        stall    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL stallflush_sb: scoreboard empty");
        end else begin
            e = sb.pop_front();
            if ({rf_w_en, rf_w_indx, rf_w_data} !== {1'b1, e.rd, e.data}) begin
                n_bad++;
                $display("FAIL stallflush_write: got en=%b idx=%0d data=%h required en=1 idx=%0d data=%h",
                         rf_w_en, rf_w_indx, rf_w_data, e.rd, e.data);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_stall();
        set_in(1'b1, 5'd8, 1'b1, 2'd0, 3'd0, 32'h0000_0088, 32'h0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        stall    = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({rf_w_en, rf_w_indx, rf_w_data, fwd_valid, fwd_rd, fwd_data, load_in_wb} !== '0) begin
            n_bad++;
            $display("FAIL midstall_reset: got en=%b idx=%0d data=%h fv=%b frd=%0d fdata=%h ld=%b required all 0",
                     rf_w_en, rf_w_indx, rf_w_data, fwd_valid, fwd_rd, fwd_data, load_in_wb);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (rf_w_en !== 1'b0) begin
            n_bad++;
            $display("FAIL midstall_nowrite: got %b required 0", rf_w_en);
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [31:0] a;
        logic [31:0] p;
        logic [1:0]  sel;
        for (int i = 0; i < 6; i++) begin
            a   = $urandom;
            p   = $urandom;
            sel = (i % 2 == 1) ? 2'd2 : 2'd0;
            set_in(1'b1, 5'(i + 11), 1'b1, sel, 3'd0, a, p);
            sb.push_back('{5'(i + 11), (sel == 2'd2) ? p : a});
            @(posedge clk); #1;
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL b2b%0d_sb: scoreboard empty", i);
            end else begin
                e = sb.pop_front();
                if ({rf_w_en, rf_w_indx, rf_w_data} !== {1'b1, e.rd, e.data}) begin
                    n_bad++;
                    $display("FAIL b2b%0d_write: got en=%b idx=%0d data=%h required en=1 idx=%0d data=%h",
                             i, rf_w_en, rf_w_indx, rf_w_data, e.rd, e.data);
                end
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

`ifdef WB_INSTRET_EN
    task automatic test_instret();
        logic [63:0] base;
        base = instret;
        set_in(1'b1, 5'd20, 1'b0, 2'd0, 3'd0, 32'h1, 32'h0);
        @(posedge clk); #1;
        set_in(1'b1, 5'd0, 1'b1, 2'd0, 3'd0, 32'h2, 32'h0);
        @(posedge clk); #1;
        set_in(1'b1, 5'd21, 1'b0, 2'd0, 3'd0, 32'h3, 32'h0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        set_in(1'b1, 5'd22, 1'b0, 2'd0, 3'd0, 32'h4, 32'h0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        stall    = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        stall = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++;
        if (instret - base !== 64'd3) begin
            n_bad++;
            $display("FAIL instret: got delta=%0d required 3", instret - base);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_load("lb_off3",   3'b000, 32'h0000_1003, 32'h80FF_1122, 32'hFFFF_FF80);
        test_load("lbu_off3",  3'b100, 32'h0000_1003, 32'h80FF_1122, 32'h0000_0080);
        test_load("lb_off0",   3'b000, 32'h0000_1000, 32'h80FF_1122, 32'h0000_0022);
        test_load("lb_off1",   3'b000, 32'h0000_1001, 32'h80FF_1122, 32'h0000_0011);
        test_load("lb_off2",   3'b000, 32'h0000_1002, 32'h80FF_1122, 32'hFFFF_FFFF);
        test_load("lh_off2",   3'b001, 32'h0000_1002, 32'h8001_0000, 32'hFFFF_8001);
        test_load("lhu_off2",  3'b101, 32'h0000_1002, 32'h8001_0000, 32'h0000_8001);
        test_load("lh_off3",   3'b001, 32'h0000_1003, 32'h8001_0000, 32'hFFFF_8001);
        test_load("lhu_off0",  3'b101, 32'h0000_1000, 32'h8001_F00D, 32'h0000_F00D);
        test_load("lw_off1",   3'b010, 32'h0000_1001, 32'h8001_0000, 32'h8001_0000);
        test_load("f3rsv_off2", 3'b011, 32'h0000_1002, 32'h1234_5678, 32'h1234_5678);
        test_stall_hold();
        test_rd0_jal();
        test_flush();
        test_stall_flush();
        test_reset_mid_stall();
        test_back_to_back();
`ifdef WB_INSTRET_EN
        test_instret();
`endif
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
